// File: rtl/prog_clock_gen_pkg.sv
// -----------------------------------------------------------------------------
// prog_clock_gen_pkg
// Shared types and constants for the programmable clock generator.
//   ch_state_t : per-channel run state (IDLE / RUN)
//   MIN_DIV    : smallest legal period in clk cycles; shorter requests are raised
//   ch_idx_w() : width of a channel-select field, never less than 1 bit
// The per-channel configuration record (div, high, en) depends on DIV_W and is
// declared as a parameterised typedef inside prog_clock_ch.
// -----------------------------------------------------------------------------
package prog_clock_gen_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    localparam int MIN_DIV = 2;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prog_clock_ch.sv
// -----------------------------------------------------------------------------
// prog_clock_ch
// One output channel of the programmable clock generator. Holds a shadow copy
// of the last accepted configuration and a pending flag; the shadow becomes
// active only while idle or on the edge that ends the current period, so the
// output never produces a runt pulse.
// Ports:
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   i_wr           : accepted write for this channel (one-cycle strobe)
//   i_div, i_high  : requested period and high time (clamped on capture)
//   i_en           : requested run (1) / stop (0)
//   i_sync         : force a period restart on the next edge while running
//   o_pend         : a written configuration is waiting to be applied
//   o_wave         : registered divided waveform
//   o_tick         : registered pulse on the first cycle of each period
//   o_running      : channel is in RUN
// -----------------------------------------------------------------------------
module prog_clock_ch
    import prog_clock_gen_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_div,
    input  logic [DIV_W-1:0] i_high,
    input  logic             i_en,
    input  logic             i_sync,
    output logic             o_pend,
    output logic             o_wave,
    output logic             o_tick,
    output logic             o_running
);

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [DIV_W-1:0] high;
        logic             en;
    } ch_cfg_t;

    localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    // High time is limited against the already-clamped period so at least one
    // low cycle always remains in every period.
    function automatic ch_cfg_t clamp_cfg(input logic [DIV_W-1:0] div,
                                          input logic [DIV_W-1:0] high,
                                          input logic             en);
        ch_cfg_t c;
        c.div  = (div < MIN_DIV_V) ? MIN_DIV_V : div;
        c.high = (high > (c.div - ONE)) ? (c.div - ONE) : high;
        c.en   = en;
        return c;
    endfunction

    ch_state_t        r_state;
    logic [DIV_W-1:0] r_cnt;
    ch_cfg_t          r_act;
    ch_cfg_t          r_shd;
    logic             r_pend;
    logic             r_wave;
    logic             r_tick;

    ch_cfg_t          w_shd_in;
    logic             w_wrap;
    logic             w_apply;
    logic [DIV_W-1:0] w_cnt_inc;

    assign w_shd_in  = clamp_cfg(i_div, i_high, i_en);
    assign w_cnt_inc = r_cnt + ONE;

    // End of period: natural wrap or forced restart; only meaningful in RUN.
    assign w_wrap  = (r_state == RUN) && ((r_cnt == (r_act.div - ONE)) || i_sync);
    assign w_apply = r_pend && ((r_state == IDLE) || w_wrap);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_act   <= '0;
            r_shd   <= '0;
            r_pend  <= 1'b0;
            r_wave  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            // A write is only possible while nothing is pending, so a write
            // and an apply never coincide.
            if (w_apply) begin
                r_act  <= r_shd;
                r_pend <= 1'b0;
            end
            if (i_wr) begin
                r_shd  <= w_shd_in;
                r_pend <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_apply && r_shd.en) begin
                        r_state <= RUN;
                        r_tick  <= 1'b1;
                        r_wave  <= (r_shd.high != '0);
                    end else begin
                        r_tick  <= 1'b0;
                        r_wave  <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_wrap) begin
                        r_cnt <= '0;
                        if (w_apply && !r_shd.en) begin
                            r_state <= IDLE;
                            r_tick  <= 1'b0;
                            r_wave  <= 1'b0;
                        end else begin
                            r_tick <= 1'b1;
                            r_wave <= w_apply ? (r_shd.high != '0) : (r_act.high != '0);
                        end
                    end else begin
                        r_cnt  <= w_cnt_inc;
                        r_tick <= 1'b0;
                        r_wave <= (w_cnt_inc < r_act.high);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_tick  <= 1'b0;
                    r_wave  <= 1'b0;
                end
            endcase
        end
    end

    assign o_pend    = r_pend;
    assign o_wave    = r_wave;
    assign o_tick    = r_tick;
    assign o_running = (r_state == RUN);

endmodule

// File: rtl/prog_clock_gen.sv
// -----------------------------------------------------------------------------
// prog_clock_gen
// Multi-channel programmable clock generator. NUM_CH independent channels each
// produce a divided waveform with run-time period, high time and enable.
// Configuration writes use a valid/ready handshake and take effect at a period
// boundary.
// Optional build macro:
//   PROG_CLOCK_GEN_SYNC_EN : adds input sync_start; a one-cycle pulse restarts
//                            every running channel on the next edge.
// Ports:
//   clk, reset_n          : system clock, asynchronous active-low reset
//   sync_start            : (PROG_CLOCK_GEN_SYNC_EN only) phase-align pulse
//   cfg_valid / cfg_ready : write handshake; cfg_ready reflects the target
//                           channel's pending flag
//   cfg_ch                : target channel (out-of-range writes are dropped)
//   cfg_div, cfg_high     : period and high time in clk cycles
//   cfg_en                : 1 = run, 0 = stop after the current period
//   wave_out, tick        : registered per-channel waveform and period pulse
//   running               : per-channel RUN indication
// -----------------------------------------------------------------------------
module prog_clock_gen
    import prog_clock_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
`ifdef PROG_CLOCK_GEN_SYNC_EN
    input  logic                        sync_start,
`endif
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic [DIV_W-1:0]            cfg_high,
    input  logic                        cfg_en,
    output logic [NUM_CH-1:0]           wave_out,
    output logic [NUM_CH-1:0]           tick,
    output logic [NUM_CH-1:0]           running
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_wr;
    logic              w_ready;
    logic              w_sync;

`ifdef PROG_CLOCK_GEN_SYNC_EN
    assign w_sync = sync_start;
`else
    assign w_sync = 1'b0;
`endif

    // Ready follows the addressed channel; unmapped channel numbers are
    // always ready so the write completes and is dropped.
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                w_ready = !w_pend[i];
            end
        end
    end

    assign cfg_ready = w_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wr[g] = cfg_valid && w_ready && (cfg_ch == CH_W'(g));

        prog_clock_ch #(
            .DIV_W (DIV_W)
        ) u_ch (
            .i_clk     (clk),
            .i_rst_n   (reset_n),
            .i_wr      (w_wr[g]),
            .i_div     (cfg_div),
            .i_high    (cfg_high),
            .i_en      (cfg_en),
            .i_sync    (w_sync),
            .o_pend    (w_pend[g]),
            .o_wave    (wave_out[g]),
            .o_tick    (tick[g]),
            .o_running (running[g])
        );
    end

endmodule

// File: tb/tb_prog_clock_gen.sv
module tb_prog_clock_gen;

    localparam int NUM_CH = 5;
    localparam int DIV_W  = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_high;
    logic              cfg_en;
    logic [NUM_CH-1:0] wave_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] running;
`ifdef PROG_CLOCK_GEN_SYNC_EN
    logic              sync_start = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prog_clock_gen #(
        .NUM_CH (NUM_CH),
        .DIV_W  (DIV_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef PROG_CLOCK_GEN_SYNC_EN
        .sync_start (sync_start),
`endif
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_high   (cfg_high),
        .cfg_en     (cfg_en),
        .wave_out   (wave_out),
        .tick       (tick),
        .running    (running)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 ns after the edge that accepted the write.
    task automatic write_cfg(input int ch, input int div, input int high, input bit en);
        int n = 0;
        cfg_ch    = 3'(ch);
        cfg_div   = 8'(div);
        cfg_high  = 8'(high);
        cfg_en    = en;
        cfg_valid = 1'b1;
        while (cfg_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        n_tests++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ready ch%0d: cfg_ready=%b required 1", ch, cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_tick(input int ch, input string name);
        int n = 0;
        while (tick[ch] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_tests++;
        if (tick[ch] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: tick[%0d]=%b required 1 within 20 cycles", name, ch, tick[ch]);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_high  = '0;
        cfg_en    = 1'b0;
        repeat (2) step();
        n_tests++;
        if ({wave_out, tick, running} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: wave=%b tick=%b running=%b required all 0", wave_out, tick, running);
        end
        n_tests++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: cfg_ready=%b required 1", cfg_ready);
        end
        reset_n = 1'b1;
        step();
        n_tests++;
        if (running !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_release: running=%b required 00000", running);
        end
    endtask

    task automatic test_basic();
        logic ew, et;
        write_cfg(0, 4, 2, 1'b1);
        for (int c = 0; c < 12; c++) begin
            step();
            ew = ((c % 4) < 2);
            et = ((c % 4) == 0);
            n_tests++;
            if (running[0] !== 1'b1 || wave_out[0] !== ew || tick[0] !== et) begin
                n_fail++;
                $display("FAIL basic c=%0d: wave=%b tick=%b running=%b required wave=%b tick=%b running=1",
                         c, wave_out[0], tick[0], running[0], ew, et);
            end
        end
    endtask

    task automatic test_reconfig();
        logic ew;
        write_cfg(1, 6, 3, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (wave_out[1] !== 1'b1 || tick[1] !== (c == 0)) begin
                n_fail++;
                $display("FAIL reconfig_old c=%0d: wave=%b tick=%b required wave=1 tick=%b",
                         c, wave_out[1], tick[1], (c == 0));
            end
        end
        cfg_ch    = 3'd1;
        cfg_div   = 8'd3;
        cfg_high  = 8'd1;
        cfg_en    = 1'b1;
        cfg_valid = 1'b1;
        n_tests++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reconfig_ready_in: cfg_ready=%b required 1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        for (int c = 3; c < 6; c++) begin
            if (c > 3) step();
            n_tests++;
            if (cfg_ready !== 1'b0 || wave_out[1] !== 1'b0 || tick[1] !== 1'b0 || running[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL reconfig_tail c=%0d: ready=%b wave=%b tick=%b running=%b required 0 0 0 1",
                         c, cfg_ready, wave_out[1], tick[1], running[1]);
            end
        end
        for (int k = 0; k < 6; k++) begin
            step();
            ew = ((k % 3) == 0);
            n_tests++;
            if (cfg_ready !== 1'b1 || wave_out[1] !== ew || tick[1] !== ew) begin
                n_fail++;
                $display("FAIL reconfig_new k=%0d: ready=%b wave=%b tick=%b required ready=1 wave=%b tick=%b",
                         k, cfg_ready, wave_out[1], tick[1], ew, ew);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ew, et;
        wait_tick(1, "b2b_align");
        write_cfg(1, 4, 3, 1'b1);
        cfg_div   = 8'd5;
        cfg_high  = 8'd0;
        cfg_en    = 1'b1;
        cfg_valid = 1'b1;
        n_tests++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_blocked: cfg_ready=%b required 0", cfg_ready);
        end
        wait_tick(1, "b2b_wrap");
        n_tests++;
        if (cfg_ready !== 1'b1 || wave_out[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_apply: ready=%b wave=%b required ready=1 wave=1", cfg_ready, wave_out[1]);
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) begin
                cfg_valid = 1'b0;
                n_tests++;
                if (cfg_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_second_accept: cfg_ready=%b required 0", cfg_ready);
                end
            end
            ew = (k < 3);
            et = (k == 4) || (k == 9);
            n_tests++;
            if (wave_out[1] !== ew || tick[1] !== et) begin
                n_fail++;
                $display("FAIL b2b k=%0d: wave=%b tick=%b required wave=%b tick=%b",
                         k, wave_out[1], tick[1], ew, et);
            end
        end
    endtask

    task automatic test_clamp();
        logic e;
        write_cfg(3, 1, 9, 1'b1);
        for (int c = 0; c < 6; c++) begin
            step();
            e = ((c % 2) == 0);
            n_tests++;
            if (running[3] !== 1'b1 || wave_out[3] !== e || tick[3] !== e) begin
                n_fail++;
                $display("FAIL clamp_div c=%0d: wave=%b tick=%b running=%b required wave=%b tick=%b running=1",
                         c, wave_out[3], tick[3], running[3], e, e);
            end
        end
        wait_tick(3, "clamp_align");
        write_cfg(3, 5, 0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step();
            e = ((k % 5) == 0);
            n_tests++;
            if (wave_out[3] !== 1'b0 || tick[3] !== e) begin
                n_fail++;
                $display("FAIL clamp_high0 k=%0d: wave=%b tick=%b required wave=0 tick=%b",
                         k, wave_out[3], tick[3], e);
            end
        end
    endtask

    task automatic test_disable();
        write_cfg(2, 8, 4, 1'b1);
        step();
        n_tests++;
        if (running[2] !== 1'b1 || tick[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL disable_start: running=%b tick=%b required 1 1", running[2], tick[2]);
        end
        step();
        step();
        write_cfg(2, 8, 4, 1'b0);
        for (int c = 3; c < 8; c++) begin
            if (c > 3) step();
            n_tests++;
            if (running[2] !== 1'b1 || tick[2] !== 1'b0 || wave_out[2] !== (c < 4)) begin
                n_fail++;
                $display("FAIL disable_finish c=%0d: running=%b tick=%b wave=%b required 1 0 %b",
                         c, running[2], tick[2], wave_out[2], (c < 4));
            end
        end
        for (int k = 0; k < 10; k++) begin
            step();
            n_tests++;
            if (running[2] !== 1'b0 || tick[2] !== 1'b0 || wave_out[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL disable_idle k=%0d: running=%b tick=%b wave=%b required 0 0 0",
                         k, running[2], tick[2], wave_out[2]);
            end
        end
        n_tests++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL disable_ready: cfg_ready=%b required 1", cfg_ready);
        end
    endtask

    task automatic test_bad_channel();
        cfg_ch    = 3'd6;
        cfg_div   = 8'd4;
        cfg_high  = 8'd2;
        cfg_en    = 1'b1;
        cfg_valid = 1'b1;
        n_tests++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_ch_ready: cfg_ready=%b required 1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        repeat (3) step();
        n_tests++;
        if (running !== 5'b01011) begin
            n_fail++;
            $display("FAIL bad_ch_running: running=%b required 01011", running);
        end
        cfg_ch = 3'd4;
        #1;
        n_tests++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_ch_ch4_ready: cfg_ready=%b required 1", cfg_ready);
        end
    endtask

`ifdef PROG_CLOCK_GEN_SYNC_EN
    task automatic test_sync();
        logic e0, e1;
        wait_tick(1, "sync_align1");
        write_cfg(1, 6, 3, 1'b1);
        wait_tick(1, "sync_apply1");
        step();
        step();
        sync_start = 1'b1;
        step();
        sync_start = 1'b0;
        n_tests++;
        if (tick[1:0] !== 2'b11 || wave_out[1:0] !== 2'b11) begin
            n_fail++;
            $display("FAIL sync_align: tick=%b wave=%b required 11 11", tick[1:0], wave_out[1:0]);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            e0 = ((k % 4) == 0);
            e1 = ((k % 6) == 0);
            n_tests++;
            if (tick[0] !== e0 || tick[1] !== e1) begin
                n_fail++;
                $display("FAIL sync_after k=%0d: tick0=%b tick1=%b required %b %b",
                         k, tick[0], tick[1], e0, e1);
            end
        end
    endtask
`endif

    task automatic test_reset_midrun();
        int n = 0;
        wait_tick(1, "midrun_align");
        write_cfg(1, 3, 1, 1'b1);
        while (wave_out[0] !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        n_tests++;
        if (wave_out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_wave_high: wave0=%b required 1", wave_out[0]);
        end
        #3;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({wave_out, tick, running} !== 15'd0) begin
            n_fail++;
            $display("FAIL midrun_async: wave=%b tick=%b running=%b required all 0", wave_out, tick, running);
        end
        step();
        reset_n = 1'b1;
        cfg_ch  = 3'd1;
        #1;
        n_tests++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_ready: cfg_ready=%b required 1", cfg_ready);
        end
        step();
        step();
        n_tests++;
        if (running !== 5'd0 || tick !== 5'd0 || wave_out !== 5'd0) begin
            n_fail++;
            $display("FAIL midrun_lost: running=%b tick=%b wave=%b required all 0", running, tick, wave_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reconfig();
        test_back_to_back();
        test_clamp();
        test_disable();
        test_bad_channel();
`ifdef PROG_CLOCK_GEN_SYNC_EN
        test_sync();
`endif
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
